mac_vec_acc: RTL and testbench

- Streaming, pipelined fixed-point multiply-accumulate engine. Computes y = sum over DEPTH beats and LANES lanes of m[i]*x[i], plus bias b.
- Successor to the single-term combinational MAC: vectorised across lanes, accumulates across beats, uses valid/ready handshakes, and adds selectable rounding and saturation.
- Sits in the mlops datapath feeding dense/conv layers.

---
 rtl/mac_vec_acc.sv | 185 ++++++++++++++++++
 tb/tb_mac_vec_acc.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vec_acc.sv
// Streaming vector multiply-accumulate: LANES products per beat, summed over DEPTH beats
// plus a bias, then requantized with optional rounding and saturation.
module mac_vec_acc #(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int IW_M  = 4,
    parameter int QW_M  = 8,
    parameter int IW_X  = 4,
    parameter int QW_X  = 8,
    parameter int IW_B  = 4,
    parameter int QW_B  = 8,
    parameter int IW_Y  = 4,
    parameter int QW_Y  = 8,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic [LANES*(IW_M+QW_M)-1:0]       m_in,
    input  logic [LANES*(IW_X+QW_X)-1:0]       x_in,
    input  logic [IW_B+QW_B-1:0]               b_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [IW_Y+QW_Y-1:0]               y_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               out_ovf
);

    localparam int WL_M  = IW_M + QW_M;
    localparam int WL_X  = IW_X + QW_X;
    localparam int WL_B  = IW_B + QW_B;
    localparam int WL_Y  = IW_Y + QW_Y;
    localparam int IW_P  = IW_M + IW_X;
    localparam int QW_P  = QW_M + QW_X;
    localparam int WP    = IW_P + QW_P;
    localparam int LG    = $clog2(LANES * DEPTH);
    localparam int IW_A0 = IW_P + LG;
    localparam int IW_A  = ((IW_A0 > IW_B) ? IW_A0 : IW_B) + 1;
    localparam int QW_A  = (QW_P > QW_B) ? QW_P : QW_B;
    localparam int WA    = IW_A + QW_A;
    localparam int SH_P  = QW_A - QW_P;
    localparam int SH_B  = QW_A - QW_B;
    localparam int CW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DROP  = (QW_A > QW_Y) ? (QW_A - QW_Y) : 0;
    localparam int PAD   = (QW_Y > QW_A) ? (QW_Y - QW_A) : 0;
    localparam int RND_SH = (DROP > 0) ? (DROP - 1) : 0;
    localparam int WT0   = WA + 1 + PAD;
    localparam int WT    = (WT0 > WL_Y + 1) ? WT0 : (WL_Y + 1);

    // Align the accumulator's binary point to the output's; the extra headroom bit
    // absorbs the rounding increment so it can never wrap.
    function automatic logic signed [WT-1:0] round_shift(input logic signed [WA-1:0] a);
        logic signed [WT-1:0] t;
        t = WT'(a);
        if (ROUND != 0 && DROP > 0)
            t = t + (WT'(1) <<< RND_SH);
        t = t >>> DROP;
        t = t <<< PAD;
        return t;
    endfunction

    // Returns {overflow, value}; on overflow either clamp or keep the low bits.
    function automatic logic [WL_Y:0] clamp(input logic signed [WT-1:0] t);
        logic signed [WT-1:0] ymax;
        logic signed [WT-1:0] ymin;
        logic [WL_Y:0]        r;
        ymax = (WT'(1) <<< (WL_Y - 1)) - WT'(1);
        ymin = -(WT'(1) <<< (WL_Y - 1));
        if (t > ymax)
            r = (SAT != 0) ? {1'b1, ymax[WL_Y-1:0]} : {1'b1, t[WL_Y-1:0]};
        else if (t < ymin)
            r = (SAT != 0) ? {1'b1, ymin[WL_Y-1:0]} : {1'b1, t[WL_Y-1:0]};
        else
            r = {1'b0, t[WL_Y-1:0]};
        return r;
    endfunction

    logic en;
    logic accept;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    logic [CW-1:0] beat;
    logic          first_c;
    logic          last_c;
    assign first_c = (beat == '0);
    assign last_c  = (beat == CW'(DEPTH - 1));

    logic signed [WP-1:0] prod_c [LANES];
    logic signed [WA-1:0] bias_c;
    always_comb begin
        for (int i = 0; i < LANES; i++)
            prod_c[i] = WP'($signed(m_in[i*WL_M +: WL_M])) * WP'($signed(x_in[i*WL_X +: WL_X]));
        bias_c = WA'($signed(b_in[WL_B-1:0])) <<< SH_B;
    end

    // Stage 1: lane products, beat position flags and aligned bias
    logic signed [WP-1:0] prod_p1 [LANES];
    logic signed [WA-1:0] bias_p1;
    logic                 vld_p1, first_p1, last_p1;

    always_ff @(posedge clk_in) begin
        if (accept) begin
            prod_p1 <= prod_c;
            bias_p1 <= bias_c;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            beat     <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else if (en) begin
            if (accept)
                beat <= last_c ? '0 : beat + 1'b1;
            vld_p1   <= in_valid;
            first_p1 <= first_c;
            last_p1  <= last_c;
        end
    end

    // Stage 2: lane reduction
    logic signed [WA-1:0] tree_c;
    always_comb begin
        tree_c = '0;
        for (int i = 0; i < LANES; i++)
            tree_c = tree_c + (WA'(prod_p1[i]) <<< SH_P);
    end

    logic signed [WA-1:0] tree_p2;
    logic signed [WA-1:0] bias_p2;
    logic                 vld_p2, first_p2, last_p2;

    always_ff @(posedge clk_in) begin
        if (en) begin
            tree_p2 <= tree_c;
            bias_p2 <= bias_p1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld_p2   <= 1'b0;
            first_p2 <= 1'b0;
            last_p2  <= 1'b0;
        end else if (en) begin
            vld_p2   <= vld_p1;
            first_p2 <= first_p1;
            last_p2  <= last_p1;
        end
    end

    // Stage 3: accumulate across beats; vld_p3 marks a completed vector
    logic signed [WA-1:0] acc_p3;
    logic                 vld_p3;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_p3 <= '0;
            vld_p3 <= 1'b0;
        end else if (en) begin
            vld_p3 <= vld_p2 && last_p2;
            if (vld_p2)
                acc_p3 <= (first_p2 ? bias_p2 : acc_p3) + tree_p2;
        end
    end

    // Output stage: requantize and hold until downstream takes it
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            y_out     <= '0;
        end else if (en) begin
            out_valid <= vld_p3;
            if (vld_p3)
                {out_ovf, y_out} <= clamp(round_shift(acc_p3));
        end
    end

endmodule

// File: tb/tb_mac_vec_acc.sv
// Randomized and directed bench for mac_vec_acc: stimulus pushes expected results into
// queues, independent monitors pop and compare whenever a result is handed off.
`timescale 1ns/1ps
module tb_mac_vec_acc;

    typedef struct packed {
        logic [11:0] y;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Shared stimulus for the rounding/saturating and truncating/wrapping instances
    logic        rst_n;
    logic [47:0] m_in, x_in;
    logic [11:0] b_in;
    logic        in_valid, out_ready;
    logic        in_ready0, in_ready1, ov0, ov1, ovf0, ovf1;
    logic [11:0] y0, y1;

    // Single-lane, single-beat instance
    logic        rst2_n, iv2, ir2, ov2, ovf2, or2;
    logic [11:0] m2, x2, b2, y2;

    mac_vec_acc dut0 (
        .clk_in(clk), .rst_n_in(rst_n), .m_in(m_in), .x_in(x_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready0), .y_out(y0), .out_valid(ov0),
        .out_ready(out_ready), .out_ovf(ovf0));

    mac_vec_acc #(.ROUND(0), .SAT(0)) dut1 (
        .clk_in(clk), .rst_n_in(rst_n), .m_in(m_in), .x_in(x_in), .b_in(b_in),
        .in_valid(in_valid), .in_ready(in_ready1), .y_out(y1), .out_valid(ov1),
        .out_ready(out_ready), .out_ovf(ovf1));

    mac_vec_acc #(.LANES(1), .DEPTH(1)) dut2 (
        .clk_in(clk), .rst_n_in(rst2_n), .m_in(m2), .x_in(x2), .b_in(b2),
        .in_valid(iv2), .in_ready(ir2), .y_out(y2), .out_valid(ov2),
        .out_ready(or2), .out_ovf(ovf2));

    res_t q0[$];
    res_t q1[$];
    res_t q2[$];

    logic [47:0] vm [4];
    logic [47:0] vx [4];
    logic [11:0] vb;
    int          last_acc;
    int          ready_mode = 0;
    bit          done2 = 0;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endfunction

    function automatic res_t mk(input logic [11:0] y, input logic o);
        res_t r;
        r.y = y;
        r.ovf = o;
        return r;
    endfunction

    // v is the exact sum in units of 2^-16; the result has 8 fractional bits
    function automatic res_t requant(input longint v, input bit rnd, input bit sat);
        res_t   r;
        longint q;
        q = rnd ? ((v + 128) >>> 8) : (v >>> 8);
        r.ovf = (q > 2047) || (q < -2048);
        if (r.ovf && sat)
            r.y = (q > 0) ? 12'h7FF : 12'h800;
        else
            r.y = q[11:0];
        return r;
    endfunction

    function automatic longint vec_value();
        longint v;
        v = longint'($signed(vb)) * 256;
        for (int d = 0; d < 4; d++)
            for (int l = 0; l < 4; l++)
                v += longint'($signed(vm[d][l*12 +: 12])) * longint'($signed(vx[d][l*12 +: 12]));
        return v;
    endfunction

    function automatic logic [11:0] rnd_val();
        logic [6:0] s;
        if ($urandom_range(0, 1) != 0)
            return 12'($urandom);
        s = 7'($urandom);
        return 12'($signed(s));
    endfunction

    task automatic fill(input logic [11:0] mv, input logic [11:0] xv, input logic [11:0] bv);
        for (int d = 0; d < 4; d++)
            for (int l = 0; l < 4; l++) begin
                vm[d][l*12 +: 12] = mv;
                vx[d][l*12 +: 12] = xv;
            end
        vb = bv;
    endtask

    task automatic fill_random();
        for (int d = 0; d < 4; d++)
            for (int l = 0; l < 4; l++) begin
                vm[d][l*12 +: 12] = rnd_val();
                vx[d][l*12 +: 12] = rnd_val();
            end
        vb = rnd_val();
    endtask

    task automatic expect_model();
        longint v;
        v = vec_value();
        q0.push_back(requant(v, 1'b1, 1'b1));
        q1.push_back(requant(v, 1'b0, 1'b0));
    endtask

    // Called and returns at negedge+2; the beat is taken at the posedge that follows.
    task automatic push_beat(input logic [47:0] mb, input logic [47:0] xb, input logic [11:0] bb);
        int g;
        m_in = mb;
        x_in = xb;
        b_in = bb;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready0 && g < 500) begin
            @(negedge clk); #2;
            g++;
        end
        if (!in_ready0) chk("accept_timeout", in_ready0, 1);
        last_acc = cyc + 1;
        @(negedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic send_vec(input int gapmax);
        int g;
        for (int d = 0; d < 4; d++) begin
            g = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
            repeat (g) begin
                @(negedge clk); #2;
            end
            push_beat(vm[d], vx[d], vb);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        do begin
            @(negedge clk); #2;
            g++;
        end while ((q0.size() != 0 || q1.size() != 0) && g < 300);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
    endtask

    initial begin
        forever begin
            @(negedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        res_t        e;
        logic [11:0] hy;
        logic        hovf;
        bit          held;
        held = 0;
        forever begin
            @(negedge clk); #3;
            if (rst_n && ov0) begin
                if (held) begin
                    chk("hold_y0", y0, hy);
                    chk("hold_ovf0", ovf0, hovf);
                end
                if (out_ready) begin
                    held = 0;
                    if (q0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected0: result %h with nothing queued", y0);
                    end else begin
                        e = q0.pop_front();
                        chk("y0", y0, e.y);
                        chk("ovf0", ovf0, e.ovf);
                    end
                end else begin
                    held = 1;
                    hy = y0;
                    hovf = ovf0;
                end
            end else begin
                held = 0;
            end
        end
    end

    initial begin
        res_t e;
        forever begin
            @(negedge clk); #3;
            if (rst_n && ov1 && out_ready) begin
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected1: result %h with nothing queued", y1);
                end else begin
                    e = q1.pop_front();
                    chk("y1", y1, e.y);
                    chk("ovf1", ovf1, e.ovf);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk); #1;
            or2 = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        res_t e;
        forever begin
            @(negedge clk); #3;
            if (rst2_n && ov2 && or2) begin
                if (q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected2: result %h with nothing queued", y2);
                end else begin
                    e = q2.pop_front();
                    chk("y2", y2, e.y);
                    chk("ovf2", ovf2, e.ovf);
                end
            end
        end
    end

    initial begin
        longint v;
        int     g;
        m2 = '0; x2 = '0; b2 = '0; iv2 = 1'b0;
        @(posedge rst2_n);
        @(negedge clk); #2;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); #2;
            end
            if (k % 4 == 0) begin
                m2 = 12'h100; x2 = 12'h100; b2 = 12'h100;
                q2.push_back(mk(12'h200, 1'b0));
            end else begin
                m2 = rnd_val(); x2 = rnd_val(); b2 = rnd_val();
                v = longint'($signed(m2)) * longint'($signed(x2)) + longint'($signed(b2)) * 256;
                q2.push_back(requant(v, 1'b1, 1'b1));
            end
            iv2 = 1'b1;
            g = 0;
            while (!ir2 && g < 500) begin
                @(negedge clk); #2;
                g++;
            end
            if (!ir2) chk("accept_timeout2", ir2, 1);
            @(negedge clk); #2;
            iv2 = 1'b0;
        end
        done2 = 1;
    end

    initial begin
        int          t;
        int          g;
        logic [11:0] yh;
        rst_n = 1'b0; rst2_n = 1'b0;
        in_valid = 1'b0; m_in = '0; x_in = '0; b_in = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valid0", ov0, 0);  chk("rst_y0", y0, 0);  chk("rst_ovf0", ovf0, 0);  chk("rst_ready0", in_ready0, 1);
        chk("rst_valid1", ov1, 0);  chk("rst_y1", y1, 0);  chk("rst_ovf1", ovf1, 0);  chk("rst_ready1", in_ready1, 1);
        chk("rst_valid2", ov2, 0);  chk("rst_y2", y2, 0);  chk("rst_ovf2", ovf2, 0);  chk("rst_ready2", ir2, 1);
        @(negedge clk); #4;
        rst_n = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk); #2;

        // Basic value and latency
        fill(12'h080, 12'h040, 12'h040);
        q0.push_back(mk(12'h240, 1'b0));
        q1.push_back(mk(12'h240, 1'b0));
        send_vec(0);
        t = last_acc;
        #1;
        g = 0;
        while (!ov0 && g < 20) begin
            @(negedge clk); #3;
            g++;
        end
        chk("latency", cyc - t, 3);
        drain();

        // Saturation and wrap
        fill(12'h100, 12'h080, 12'h040);
        q0.push_back(mk(12'h7FF, 1'b1));
        q1.push_back(mk(12'h840, 1'b1));
        send_vec(0);
        fill(12'hF00, 12'h100, 12'h000);
        q0.push_back(mk(12'h800, 1'b1));
        q1.push_back(mk(12'h000, 1'b1));
        send_vec(0);
        drain();

        // Rounding versus truncation on a half-LSB value
        fill(12'h000, 12'h000, 12'h000);
        vm[0][11:0] = 12'h080;
        vx[0][11:0] = 12'h001;
        q0.push_back(mk(12'h001, 1'b0));
        q1.push_back(mk(12'h000, 1'b0));
        send_vec(0);
        vm[0][11:0] = 12'hF80;
        q0.push_back(mk(12'h000, 1'b0));
        q1.push_back(mk(12'hFFF, 1'b0));
        send_vec(0);
        drain();

        // Backpressure: first result held for 10 cycles while more vectors stream in
        ready_mode = 2;
        fork
            begin
                for (int n = 0; n < 3; n++) begin
                    fill_random();
                    expect_model();
                    send_vec(0);
                end
            end
            begin
                #1;
                g = 0;
                while (!ov0 && g < 50) begin
                    @(negedge clk); #3;
                    g++;
                end
                chk("bp_valid", ov0, 1);
                yh = y0;
                repeat (10) begin
                    @(negedge clk); #3;
                    chk("bp_in_ready", in_ready0, 0);
                    chk("bp_y_stable", y0, yh);
                end
                ready_mode = 0;
            end
        join
        drain();

        // Asynchronous reset with a result pending and a partial vector in flight
        ready_mode = 2;
        fill(12'h080, 12'h040, 12'h040);
        q0.push_back(mk(12'h240, 1'b0));
        q1.push_back(mk(12'h240, 1'b0));
        send_vec(0);
        push_beat(vm[0], vx[0], vb);
        push_beat(vm[1], vx[1], vb);
        #1;
        g = 0;
        while (!ov0 && g < 20) begin
            @(negedge clk); #3;
            g++;
        end
        chk("pre_rst_valid", ov0, 1);
        #1;
        rst_n = 1'b0;
        #2;
        chk("arst_valid0", ov0, 0);
        chk("arst_y0", y0, 0);
        chk("arst_ready0", in_ready0, 1);
        chk("arst_valid1", ov1, 0);
        q0.delete();
        q1.delete();
        ready_mode = 0;
        @(negedge clk); #4;
        rst_n = 1'b1;
        @(negedge clk); #2;
        q0.push_back(mk(12'h240, 1'b0));
        q1.push_back(mk(12'h240, 1'b0));
        send_vec(0);
        drain();

        // Random vectors, each sent gap-free and again with bubbles, under random backpressure
        ready_mode = 1;
        for (int n = 0; n < 6; n++) begin
            fill_random();
            expect_model();
            send_vec(0);
            expect_model();
            send_vec(3);
        end
        drain();
        ready_mode = 0;

        g = 0;
        while ((!done2 || q2.size() != 0) && g < 2000) begin
            @(negedge clk); #2;
            g++;
        end
        chk("done2", done2, 1);
        chk("drain_q2", q2.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
